// File: rtl/feeder_pkg.sv
// ============================================================================
//  Module      : feeder_pkg
//  Description : Shared state encoding and watchdog limit for inst_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package feeder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_LATCH   = 4'd2,
        ST_LOAD    = 4'd3,
        ST_START   = 4'd4,
        ST_WAIT_LO = 4'd5,
        ST_WAIT_HI = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } feeder_state_t;

    localparam int                WDOG_W     = 8;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 8'd255;

    function automatic logic is_wait_state(input feeder_state_t s);
        return (s == ST_WAIT_LO) || (s == ST_WAIT_HI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/feeder_watchdog.sv
// ============================================================================
//  Module      : feeder_watchdog
//  Description : Saturating cycle counter; expired once WDOG_LIMIT is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module feeder_watchdog
    import feeder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wdog_cnt <= '0;
        end else if (enable && (wdog_cnt != WDOG_LIMIT)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign expired = (wdog_cnt == WDOG_LIMIT);

endmodule

`default_nettype wire

// File: rtl/inst_feeder.sv
// ============================================================================
//  Module      : inst_feeder
//  Description : Streams prog_len instructions from memory into a CPU via a
//                load/start/wait handshake. Optional watchdog on CPU waits is
//                enabled by defining INST_FEEDER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_feeder
    import feeder_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] prog_len,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          cpu_w,
    output logic [DW-1:0] cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] count,
    output logic          err
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    feeder_state_t state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [AW-1:0] count_nxt;
    logic [DW-1:0] cpu_in_nxt;
    logic          wdog_expired;

`ifdef INST_FEEDER_TIMEOUT_EN
    // Cleared outside the wait states so each instruction gets a full budget.
    feeder_watchdog u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!is_wait_state(state)),
        .enable  (is_wait_state(state)),
        .expired (wdog_expired)
    );
    assign err = (state == ST_ERR);
`else
    assign wdog_expired = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            addr   <= '0;
            count  <= '0;
            cpu_in <= '0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            count  <= count_nxt;
            cpu_in <= cpu_in_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        count_nxt  = count;
        cpu_in_nxt = cpu_in;
        cpu_load   = 1'b0;
        cpu_s      = 1'b0;
        done       = 1'b0;
        busy       = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_nxt  = '0;
                    count_nxt = '0;
                    state_nxt = (prog_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                cpu_in_nxt = imem_data;
                state_nxt  = ST_LOAD;
            end
            ST_LOAD: begin
                cpu_load  = 1'b1;
                state_nxt = ST_START;
            end
            ST_START: begin
                // Only kick the CPU once its controller is back in its wait state.
                if (cpu_w) begin
                    cpu_s     = 1'b1;
                    state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (wdog_expired) begin
                    state_nxt = ST_ERR;
                end else if (!cpu_w) begin
                    state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (wdog_expired) begin
                    state_nxt = ST_ERR;
                end else if (cpu_w) begin
                    count_nxt = count + ADDR_ONE;
                    if (addr == (prog_len - ADDR_ONE)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        addr_nxt  = addr + ADDR_ONE;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = addr;

endmodule

`default_nettype wire

// File: tb/tb_inst_feeder.sv
// ============================================================================
//  Module      : tb_inst_feeder
//  Description : Scoreboard bench for inst_feeder with a memory and CPU model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_feeder;

    localparam int AW = 8;
    localparam int DW = 16;

    localparam int SEL_LOAD = 0;
    localparam int SEL_S    = 1;
    localparam int SEL_DONE = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] prog_len;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          cpu_w;
    logic [DW-1:0] cpu_in;
    logic          cpu_load;
    logic          cpu_s;
    logic          busy;
    logic          done;
    logic [AW-1:0] count;
    logic          err;

    logic          w_model;
    logic          w_hold;
    logic          stuck;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] exp_q [$];

    int n_tests  = 0;
    int n_fail   = 0;
    int load_cnt = 0;
    int s_cnt    = 0;
    int done_cnt = 0;

    assign cpu_w = w_model & ~w_hold;

    always #5 clk = ~clk;

    inst_feeder #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_len  (prog_len),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .cpu_w     (cpu_w),
        .cpu_in    (cpu_in),
        .cpu_load  (cpu_load),
        .cpu_s     (cpu_s),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .err       (err)
    );

    // Synchronous-read instruction memory
    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // CPU model: w drops one cycle after s and comes back three cycles later
    initial begin
        forever begin
            @(negedge clk); #3;
            if (cpu_s && !reset) begin
                @(posedge clk); #1 w_model = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                if (!stuck) w_model = 1'b1;
            end
        end
    end

    // Output monitor and scoreboard pop
    initial begin
        forever begin
            @(negedge clk); #3;
            if (!reset) begin
                if (cpu_load && cpu_s) check_value("load_s_overlap", 32'd1, 32'd0);
                if (cpu_load) begin
                    load_cnt++;
                    if (exp_q.size() == 0) check_value("load_with_empty_scoreboard", 32'd1, 32'd0);
                    else                   check_value("cpu_in", 32'(cpu_in), 32'(exp_q.pop_front()));
                end
                if (cpu_s) s_cnt++;
                if (done)  done_cnt++;
            end
        end
    end

    function automatic int sel_cnt(input int sel);
        case (sel)
            SEL_LOAD: return load_cnt;
            SEL_S:    return s_cnt;
            default:  return done_cnt;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sel_cnt(sel) >= target) break;
            @(negedge clk); #1;
        end
        if (sel_cnt(sel) < target) check_value(tag, 32'(sel_cnt(sel)), 32'(target));
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        prog_len = AW'(len);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Runs mem[0..len-1]; optionally pulses start again while busy
    task automatic run_prog(input int len, input bit mid_start, input string tag);
        int bl, bs, bd;
        for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
        bl = load_cnt; bs = s_cnt; bd = done_cnt;
        pulse_start(len);
        if (mid_start) begin
            wait_for(SEL_LOAD, bl + 1, 50, {tag, "_first_load_timeout"});
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_for(SEL_DONE, bd + 1, 40 * len + 100, {tag, "_done_timeout"});
        check_value({tag, "_count"},  32'(count), 32'(len));
        check_value({tag, "_loads"},  32'(load_cnt - bl), 32'(len));
        check_value({tag, "_starts"}, 32'(s_cnt - bs), 32'(len));
        check_value({tag, "_dones"},  32'(done_cnt - bd), 32'd1);
        check_value({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check_value({tag, "_busy"},     32'(busy), 32'd0);
        check_value({tag, "_count"},    32'(count), 32'd0);
        check_value({tag, "_cpu_in"},   32'(cpu_in), 32'd0);
        check_value({tag, "_cpu_load"}, 32'(cpu_load), 32'd0);
        check_value({tag, "_cpu_s"},    32'(cpu_s), 32'd0);
        check_value({tag, "_done"},     32'(done), 32'd0);
        check_value({tag, "_err"},      32'(err), 32'd0);
        check_value({tag, "_addr"},     32'(imem_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int bl, bs, bd;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1; start = 1'b0; prog_len = '0;
        w_model = 1'b1; w_hold = 1'b0; stuck = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_idle_zero("reset");
        reset = 1'b0;

        // Three instructions A, B, C in order
        mem[0] = 16'hA11A; mem[1] = 16'hB22B; mem[2] = 16'hC33C;
        run_prog(3, 1'b0, "abc");
        repeat (5) @(negedge clk);
        #1;
        check_value("count_hold", 32'(count), 32'd3);
        check_value("idle_busy",  32'(busy), 32'd0);

        // Zero-length program: done right after start, no CPU traffic
        bl = load_cnt; bs = s_cnt;
        @(negedge clk);
        prog_len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_value("len0_done",  32'(done), 32'd1);
        check_value("len0_busy",  32'(busy), 32'd1);
        check_value("len0_count", 32'(count), 32'd0);
        @(negedge clk); #1;
        check_value("len0_done_off", 32'(done), 32'd0);
        check_value("len0_idle",     32'(busy), 32'd0);
        check_value("len0_no_load",  32'(load_cnt - bl), 32'd0);
        check_value("len0_no_s",     32'(s_cnt - bs), 32'd0);

        // Single instruction
        mem[0] = DW'($urandom_range(0, 65535));
        run_prog(1, 1'b0, "len1");

        // Start pulsed mid-run is ignored
        for (int i = 0; i < 5; i++) mem[i] = DW'($urandom_range(0, 65535));
        run_prog(5, 1'b1, "midstart");

        // CPU not ready on entering START: s held low until cpu_w returns
        mem[0] = 16'h5A5A;
        exp_q.push_back(mem[0]);
        w_hold = 1'b1;
        bl = load_cnt; bd = done_cnt;
        pulse_start(1);
        wait_for(SEL_LOAD, bl + 1, 50, "stall_load_timeout");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            check_value("stall_s_low", 32'(cpu_s), 32'd0);
        end
        w_hold = 1'b0;
        #1 check_value("stall_s_release", 32'(cpu_s), 32'd1);
        wait_for(SEL_DONE, bd + 1, 100, "stall_done_timeout");
        check_value("stall_count", 32'(count), 32'd1);

        // Reset in WAIT_HI of the second instruction
        for (int i = 0; i < 4; i++) mem[i] = DW'($urandom_range(0, 65535));
        for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
        bs = s_cnt;
        pulse_start(4);
        wait_for(SEL_S, bs + 2, 200, "midreset_s_timeout");
        @(negedge clk); #1;
        check_value("midreset_count_before", 32'(count), 32'd1);
        check_value("midreset_busy_before",  32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        check_idle_zero("midreset");
        reset = 1'b0;
        exp_q.delete();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) mem[i] = DW'($urandom_range(0, 65535));
        run_prog(3, 1'b0, "rerun");

        // Longer run with random contents
        for (int i = 0; i < 20; i++) mem[i] = DW'($urandom_range(0, 65535));
        run_prog(20, 1'b0, "len20");

        // CPU stuck low after s
        stuck = 1'b1;
        mem[0] = 16'hDEAD;
        exp_q.push_back(mem[0]);
        bs = s_cnt; bd = done_cnt;
        pulse_start(1);
        wait_for(SEL_S, bs + 1, 50, "stuck_s_timeout");
        repeat (100) @(negedge clk);
        #1;
        check_value("stuck_err_early", 32'(err), 32'd0);
        check_value("stuck_busy_early", 32'(busy), 32'd1);
        repeat (200) @(negedge clk);
        #1;
`ifdef INST_FEEDER_TIMEOUT_EN
        check_value("stuck_err", 32'(err), 32'd1);
`else
        check_value("stuck_err", 32'(err), 32'd0);
`endif
        check_value("stuck_busy", 32'(busy), 32'd1);
        check_value("stuck_no_done", 32'(done_cnt - bd), 32'd0);
        reset = 1'b1;
        @(negedge clk); #1;
        check_value("stuck_reset_err",  32'(err), 32'd0);
        check_value("stuck_reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        stuck = 1'b0;
        w_model = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_feeder.md
INST_FEEDER -- requirements
Module: inst_feeder

Interface
REQ-001 Parameter AW, default 8: instruction-memory address width.
REQ-002 Parameter DW, default 16: instruction width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin program run; sampled only in IDLE.
REQ-006 prog_len  input  AW  number of instructions to run, addresses 0..prog_len-1.
REQ-007 imem_addr  output  AW  instruction-memory read address.
REQ-008 imem_data  input  DW  instruction-memory read data, valid one cycle after imem_addr.
REQ-009 cpu_w  input  1  CPU wait flag; high = CPU controller idle in its wait state.
REQ-010 cpu_in  output  DW  registered instruction word to CPU.
REQ-011 cpu_load  output  1  one-cycle load strobe for CPU instruction register.
REQ-012 cpu_s  output  1  one-cycle start strobe to CPU controller.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the run completes.
REQ-015 count  output  AW  instructions completed in current/last run.
REQ-016 err  output  1  watchdog error flag (see Configuration).

Function
REQ-017 States SHALL be IDLE, FETCH, LATCH, LOAD, START, WAIT_LO, WAIT_HI, DONE, ERR.
REQ-018 IDLE: start=1 and prog_len=0 SHALL go to DONE; start=1 otherwise SHALL clear addr and count and go to FETCH.
REQ-019 FETCH: imem_addr = addr; next state LATCH unconditionally.
REQ-020 LATCH: cpu_in SHALL capture imem_data at the clock edge; next LOAD.
REQ-021 LOAD: cpu_load=1 for exactly this cycle with cpu_in stable; next START.
REQ-022 START: cpu_s=1 only while cpu_w=1, then WAIT_LO; while cpu_w=0 SHALL hold in START with cpu_s=0.
REQ-023 WAIT_LO: hold until cpu_w=0, then WAIT_HI.
REQ-024 WAIT_HI: hold until cpu_w=1; then count increments; if addr = prog_len-1 go to DONE, else addr increments and go to FETCH.
REQ-025 Per-instruction latency SHALL be 4 cycles (FETCH..START) plus CPU execution time.
REQ-026 DONE: done=1 for one cycle; next IDLE; count retains final value until next start.
REQ-027 start while busy=1 SHALL be ignored; start held high after DONE SHALL launch a new run from IDLE.
REQ-028 addr and count arithmetic is AW-bit unsigned; prog_len=2^AW-1 max, no wrap within a run.
REQ-029 cpu_load and cpu_s SHALL never be high in the same cycle.

Reset
REQ-030 reset=1 at any time, including mid-run, SHALL force IDLE, addr=0, count=0, cpu_in=0, cpu_load=0, cpu_s=0, done=0, err=0, busy=0 on the next edge.

Configuration
REQ-031 Macro INST_FEEDER_TIMEOUT_EN defined: an 8-bit watchdog counts cycles spent in WAIT_LO/WAIT_HI per instruction; reaching 255 SHALL go to ERR, set err=1, hold until reset.
REQ-032 Macro undefined: no watchdog, err tied 0, ERR unreachable, waits are unbounded.

Structure
REQ-033 Shared package feeder_pkg SHALL hold the state encoding constants and the watchdog limit (255).
REQ-034 Watchdog SHALL be sub-module feeder_watchdog (clear, enable, expired), instantiated only under INST_FEEDER_TIMEOUT_EN.

Verification
REQ-035 prog_len=3, memory {A,B,C}, CPU model drops w 1 cycle after s, restores after 3 -> cpu_load pulses with cpu_in=A,B,C in order, done pulse, count=3.
REQ-036 prog_len=0, start=1 -> done pulse on the second edge, no cpu_load/cpu_s, count=0.
REQ-037 cpu_w=0 on entering START for 5 cycles -> cpu_s held low, asserted the cycle cpu_w returns high.
REQ-038 reset asserted in WAIT_HI of instruction 2 -> next cycle busy=0, count=0, outputs zero; fresh start re-runs from addr 0.
REQ-039 start pulsed during run -> ignored, run length unchanged.
REQ-040 With INST_FEEDER_TIMEOUT_EN, cpu_w stuck low after s -> err=1 after 255 wait cycles, busy stays 1 until reset; without macro, feeder waits indefinitely, err=0.
